bram_readback_checker: RTL and testbench

//  Read-side verifier for a single-port block RAM loaded with a linear pattern.
//  On start it drives addresses 0..DEPTH-1, one per cycle, with wea held 0.

---
 rtl/bram_readback_checker.sv | 139 +++++++++++++
 tb/tb_bram_readback_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_readback_checker.sv
// Read-side verifier for a block RAM preloaded with the pattern mem[A] = A + BASE_VAL.
// Sweeps every address once, then reports the mismatch count, the first bad address and pass.
module bram_readback_checker #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned BASE_VAL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] addra,
   output logic              wea,
   input  logic [DATA_W-1:0] douta,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] first_err_addr
);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addra_q, addra_d;
   logic [1:0]          drain_q, drain_d;
   logic                pass_q, pass_d;
   logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0]   first_q, first_d;

   // Tag pipeline: stage RD_LAT-1 lines up with the douta word for its address.
   logic [RD_LAT-1:0]   tag_vld_q;
   logic [ADDR_W-1:0]   tag_addr_q [RD_LAT];

   logic                cmp_vld;
   logic [ADDR_W-1:0]   cmp_addr;
   logic [DATA_W-1:0]   exp_data;
   logic                mismatch;

   assign cmp_vld  = tag_vld_q[RD_LAT-1];
   assign cmp_addr = tag_addr_q[RD_LAT-1];
   assign exp_data = DATA_W'(cmp_addr) + DATA_W'(BASE_VAL);
   assign mismatch = cmp_vld && (douta != exp_data);

   always_comb begin
      state_d   = state_q;
      addra_d   = addra_q;
      drain_d   = drain_q;
      pass_d    = pass_q;
      err_cnt_d = err_cnt_q;
      first_d   = first_q;

      if (mismatch) begin
         err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
         if (err_cnt_q == '0) begin
            first_d = cmp_addr;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRead;
               addra_d   = '0;
               err_cnt_d = '0;
               first_d   = '0;
               pass_d    = 1'b0;
            end
         end
         StRead: begin
            if (addra_q == ADDR_W'(DEPTH - 1)) begin
               state_d = StDrain;
               drain_d = '0;
            end else begin
               addra_d = addra_q + ADDR_W'(1);
            end
         end
         StDrain: begin
            // The last compare lands on this same edge, so pass must see err_cnt_d.
            if (drain_q == 2'(RD_LAT - 1)) begin
               state_d = StDone;
               pass_d  = (err_cnt_d == '0);
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         addra_q   <= '0;
         drain_q   <= '0;
         pass_q    <= 1'b0;
         err_cnt_q <= '0;
         first_q   <= '0;
      end else begin
         state_q   <= state_d;
         addra_q   <= addra_d;
         drain_q   <= drain_d;
         pass_q    <= pass_d;
         err_cnt_q <= err_cnt_d;
         first_q   <= first_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_addr_q[i] <= '0;
         end
      end else begin
         tag_vld_q[0]  <= (state_q == StRead);
         tag_addr_q[0] <= addra_q;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_q[i]  <= tag_vld_q[i-1];
            tag_addr_q[i] <= tag_addr_q[i-1];
         end
      end
   end

   assign addra          = addra_q;
   assign wea            = 1'b0;
   assign busy           = (state_q != StIdle);
   assign done           = (state_q == StDone);
   assign pass           = pass_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_q;

endmodule

// File: tb/tb_bram_readback_checker.sv
// Bench for bram_readback_checker: one instance with a 1-cycle RAM and one with a 2-cycle RAM,
// each fed from its own memory image and checked against a whole-memory reference scan.
module tb_bram_readback_checker;

   localparam int ADDR_W   = 10;
   localparam int DATA_W   = 16;
   localparam int DEPTH    = 1024;
   localparam int BASE_VAL = 1;

   logic              clk;
   logic              rst;
   logic              start          [2];
   logic [ADDR_W-1:0] addra          [2];
   logic              wea            [2];
   logic [DATA_W-1:0] douta          [2];
   logic              busy           [2];
   logic              done           [2];
   logic              pass           [2];
   logic [ADDR_W:0]   err_cnt        [2];
   logic [ADDR_W-1:0] first_err_addr [2];
   logic [DATA_W-1:0] mem            [2][DEPTH];

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int Lat = g + 1;
      logic [DATA_W-1:0] rd_pipe [Lat];

      always @(posedge clk) begin
         rd_pipe[0] <= mem[g][addra[g]];
         for (int i = 1; i < Lat; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
      assign douta[g] = rd_pipe[Lat-1];

      bram_readback_checker #(
         .ADDR_W   (ADDR_W),
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .RD_LAT   (Lat),
         .BASE_VAL (BASE_VAL)
      ) u_dut (
         .clk            (clk),
         .rst            (rst),
         .start          (start[g]),
         .addra          (addra[g]),
         .wea            (wea[g]),
         .douta          (douta[g]),
         .busy           (busy[g]),
         .done           (done[g]),
         .pass           (pass[g]),
         .err_cnt        (err_cnt[g]),
         .first_err_addr (first_err_addr[g])
      );
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_clean(input int d);
      for (int a = 0; a < DEPTH; a++) mem[d][a] = DATA_W'(a + BASE_VAL);
   endtask

   // Reference: scan the whole image for words that break the linear pattern.
   task automatic model(input int d, output int cnt, output int first);
      cnt   = 0;
      first = 0;
      for (int a = 0; a < DEPTH; a++) begin
         if (mem[d][a] != DATA_W'(a + BASE_VAL)) begin
            if (cnt == 0) first = a;
            cnt++;
         end
      end
   endtask

   task automatic check_idle(input int d, input string pfx);
      check_eq({pfx, "_addra"}, 32'(addra[d]), 0);
      check_eq({pfx, "_busy"}, 32'(busy[d]), 0);
      check_eq({pfx, "_done"}, 32'(done[d]), 0);
      check_eq({pfx, "_pass"}, 32'(pass[d]), 0);
      check_eq({pfx, "_err_cnt"}, 32'(err_cnt[d]), 0);
      check_eq({pfx, "_first"}, 32'(first_err_addr[d]), 0);
      check_eq({pfx, "_wea"}, 32'(wea[d]), 0);
   endtask

   // Called just after a negedge; returns at the negedge in the cycle after done,
   // so consecutive calls start back-to-back.
   task automatic run_pass(input int d, input string name);
      int    exp_cnt, exp_first, lat, done_k, n_done, addr_bad, wea_hi;
      string pfx;
      pfx      = $sformatf("d%0d_%s", d, name);
      lat      = d + 1;
      done_k   = -1;
      n_done   = 0;
      addr_bad = 0;
      wea_hi   = 0;
      model(d, exp_cnt, exp_first);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      check_eq({pfx, "_busy_start"}, 32'(busy[d]), 1);
      check_eq({pfx, "_addra_start"}, 32'(addra[d]), 0);
      check_eq({pfx, "_cnt_clr"}, 32'(err_cnt[d]), 0);
      check_eq({pfx, "_pass_clr"}, 32'(pass[d]), 0);
      for (int k = 1; k <= DEPTH + lat + 1; k++) begin
         @(negedge clk);
         if (wea[d]) wea_hi++;
         if (k < DEPTH && addra[d] != ADDR_W'(k)) addr_bad++;
         if (done[d]) begin
            n_done++;
            done_k = k;
            check_eq({pfx, "_cnt_at_done"}, 32'(err_cnt[d]), exp_cnt);
            check_eq({pfx, "_first_at_done"}, 32'(first_err_addr[d]), exp_first);
            check_eq({pfx, "_busy_at_done"}, 32'(busy[d]), 1);
         end
      end
      check_eq({pfx, "_done_count"}, n_done, 1);
      check_eq({pfx, "_done_edge"}, done_k, DEPTH + lat);
      check_eq({pfx, "_addr_seq_bad"}, addr_bad, 0);
      check_eq({pfx, "_wea_high"}, wea_hi, 0);
      check_eq({pfx, "_busy_after"}, 32'(busy[d]), 0);
      check_eq({pfx, "_pass"}, 32'(pass[d]), (exp_cnt == 0) ? 1 : 0);
      check_eq({pfx, "_cnt_held"}, 32'(err_cnt[d]), exp_cnt);
      check_eq({pfx, "_first_held"}, 32'(first_err_addr[d]), exp_first);
   endtask

   task automatic scenario(input int d);
      int n;
      load_clean(d);
      run_pass(d, "clean");
      mem[d][500] = 16'hDEAD;
      run_pass(d, "one_bad");
      load_clean(d);
      run_pass(d, "b2b_clean");
      load_clean(d);
      mem[d][0]    = 16'h0000;
      mem[d][300]  = 16'hFFFF;
      mem[d][1023] = 16'h1234;
      run_pass(d, "edges");
      for (int r = 0; r < 3; r++) begin
         load_clean(d);
         n = $urandom_range(0, 5);
         for (int i = 0; i < n; i++) mem[d][$urandom_range(0, DEPTH - 1)] = DATA_W'($urandom);
         run_pass(d, $sformatf("rnd%0d", r));
      end
   endtask

   task automatic reset_test;
      int guard, n_done;
      n_done = 0;
      load_clean(0);
      mem[0][10] = 16'h0000;
      mem[0][20] = 16'h0000;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      guard = 0;
      while (addra[0] != ADDR_W'(200) && guard < 4 * DEPTH) begin
         @(negedge clk);
         guard++;
      end
      check_eq("rst_reach200", 32'(addra[0]), 200);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      check_eq("rst_midstart_ignored", 32'(addra[0]), 201);
      guard = 0;
      while (addra[0] != ADDR_W'(400) && guard < 4 * DEPTH) begin
         @(negedge clk);
         if (done[0]) n_done++;
         guard++;
      end
      check_eq("rst_reach400", 32'(addra[0]), 400);
      check_eq("rst_partial_cnt", 32'(err_cnt[0]), 2);
      check_eq("rst_partial_first", 32'(first_err_addr[0]), 10);
      rst = 1'b0;
      #1;
      check_idle(0, "rst_async");
      repeat (2) begin
         @(negedge clk);
         if (done[0]) n_done++;
      end
      rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (done[0]) n_done++;
      end
      check_eq("rst_no_done", n_done, 0);
      check_idle(0, "rst_after");
      load_clean(0);
      run_pass(0, "rst_fresh");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b0;
      start[0] = 1'b0;
      start[1] = 1'b0;
      load_clean(0);
      load_clean(1);
      repeat (3) @(negedge clk);
      check_idle(0, "d0_reset");
      check_idle(1, "d1_reset");
      rst = 1'b1;
      @(negedge clk);
      fork
         scenario(0);
         scenario(1);
      join
      @(negedge clk);
      reset_test();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
